downstream_token_out: RTL and testbench
=======================================

Name: downstream_token_out

Overview:
- Receive-side counterpart of the upstream token-credit link.
- Reassembles 2-channel, 8-bit-per-channel io beats into 64-bit words and buffers them in a credit-sized FIFO for the core.
- Returns flow-control credit to the upstream by toggling io_token_o once per 2^LG_TOKEN_DECIMATION words the core consumes.
- Sits in the io clock domain, directly facing the upstream io_data_out_ch0/ch1 and io_valid_out pins.

Parameters:
- WIDTH, 64, core word width.
- CH_WIDTH, 8, bits per io channel per beat.
- NUM_CH, 2, io channels. Beats per word = WIDTH/(CH_WIDTH*NUM_CH) = 4.
- LG_FIFO_DEPTH, 3, log2 FIFO depth (8 words). Must equal the upstream credit count.
- LG_TOKEN_DECIMATION, 2, log2 words consumed per token toggle. Must be <= LG_FIFO_DEPTH.

Ports:
- clk  in  1  io clock; all state on posedge.
- rst_n  in  1  synchronous, active-low reset.
- io_valid_in  in  1  beat valid from upstream.
- io_data_ch0_i  in  8  channel 0 beat data.
- io_data_ch1_i  in  8  channel 1 beat data.
- io_token_o  out  1  credit return toggle to upstream token input.
- core_valid_o  out  1  FIFO head valid.
- core_data_o  out  64  FIFO head word.
- core_yumi_i  in  1  core consumes head this cycle.
- overflow_o  out  1  sticky: a word arrived with the FIFO full.

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Reset values: io_token_o=0, core_valid_o=0, overflow_o=0, core_data_o=0. Beat counter, FIFO pointers and token counter are cleared.
- Assembly beat counter (2 bits, states BEAT0..BEAT3):
  - Advances only on io_valid_in=1.
  - Gaps (io_valid_in=0) hold state; no timeout.
  - Beat k writes word bits [16k+7:16k] from ch0 and [16k+15:16k+8] from ch1.
  - BEAT3 with io_valid_in wraps to BEAT0 and asserts an internal push for one cycle. The word is registered.
- Latency: core_valid_o rises the cycle after the final beat's edge, i.e. 1 cycle after beat 3 is sampled, when the FIFO was empty.
- FIFO:
  - Depth 2^LG_FIFO_DEPTH; occupancy count is LG_FIFO_DEPTH+1 bits.
  - core_valid_o = (count != 0); core_data_o = head entry, stable while core_yumi_i=0.
  - Pop on core_yumi_i & core_valid_o. core_yumi_i while core_valid_o=0 is ignored: no pop, no token.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged. Legal at full and at empty+1.
  - Push at full with no pop: word dropped, count unchanged, overflow_o set next cycle and held until reset.
- Token generation:
  - LG_TOKEN_DECIMATION-bit consumed counter increments on each pop and wraps naturally.
  - A pop while the counter is all-ones toggles io_token_o, registered, so it is visible the cycle after that pop.
  - Exactly one toggle per 2^LG_TOKEN_DECIMATION pops.
  - Partial groups carry over indefinitely.
- Reset mid-word: partial assembly is discarded and the next valid beat is treated as BEAT0. FIFO contents are lost. io_token_o returns to 0 and the upstream is reset alongside.

Optional Feature:
- Macro: DOWNSTREAM_TOKEN_CNT_EN.
- Defined:
  - Adds output token_cnt_o [6:0], reset 0, which increments by 1 with each io_token_o toggle and wraps 127->0.
  - Adds output words_rcvd_o [6:0], reset 0, which increments on every completed word including dropped ones and wraps 127->0.
  - Used for credit accounting against the upstream finish/sent counters.
- Undefined: neither port exists; no counter logic; all other behaviour identical.

Test Plan:
- Single word: 4 valid beats (ch0,ch1) = (11,22),(33,44),(55,66),(77,88) -> core_valid_o=1 one cycle after beat 4; core_data_o=64'h8877665544332211; io_token_o unchanged.
- Beat gaps: the same 4 beats with 3 idle cycles between each -> identical word; no spurious push during gaps.
- Token decimation: push 8 words, yumi each as it appears -> io_token_o toggles 0->1 the cycle after the 4th pop and 1->0 after the 8th; exactly 2 toggles.
- Full/overflow: push 8 words with yumi=0 -> count 8, overflow_o=0. 9th word -> overflow_o=1 and held. Drain 8 pops returns words 1-8 in order; 9th never appears.
- Simultaneous push/pop at full: FIFO holds 8, final beat of word 9 coincides with yumi -> count stays 8, overflow_o=0, word 9 at tail.
- Reset mid-word: 2 beats, then rst_n=0 for 1 cycle, then 4 new beats -> one word from the new beats only; io_token_o=0. With DOWNSTREAM_TOKEN_CNT_EN, token_cnt_o=0 and words_rcvd_o=1.

Source files
------------

// File: rtl/downstream_token_out.sv
// Receive side of the token-credit io link: reassembles 4 beats of 2x8-bit io data into 64-bit words,
// buffers them in a credit-sized FIFO and toggles io_token_o per 2^LG_TOKEN_DECIMATION pops.
// Optional counters via `define DOWNSTREAM_TOKEN_CNT_EN.
module downstream_token_out #(
   parameter int unsigned WIDTH               = 64,
   parameter int unsigned CH_WIDTH            = 8,
   parameter int unsigned NUM_CH              = 2,
   parameter int unsigned LG_FIFO_DEPTH       = 3,
   parameter int unsigned LG_TOKEN_DECIMATION = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                io_valid_in,
   input  logic [CH_WIDTH-1:0] io_data_ch0_i,
   input  logic [CH_WIDTH-1:0] io_data_ch1_i,
   output logic                io_token_o,
   output logic                core_valid_o,
   output logic [WIDTH-1:0]    core_data_o,
   input  logic                core_yumi_i,
   output logic                overflow_o
`ifdef DOWNSTREAM_TOKEN_CNT_EN
   ,
   output logic [6:0]          token_cnt_o,
   output logic [6:0]          words_rcvd_o
`endif
);

   localparam int unsigned BEAT_BITS = CH_WIDTH * NUM_CH;
   localparam int unsigned BEATS     = WIDTH / BEAT_BITS;
   localparam int unsigned BEAT_W    = $clog2(BEATS);
   localparam int unsigned DEPTH     = 1 << LG_FIFO_DEPTH;
   localparam int unsigned CNT_W     = LG_FIFO_DEPTH + 1;

   logic [BEAT_W-1:0]              beat_q;
   logic [WIDTH-1:0]               asm_q;
   logic [WIDTH-1:0]               word_c;
   logic [BEAT_BITS-1:0]           beat_data_c;
   logic [WIDTH-1:0]               mem_q [DEPTH];
   logic [LG_FIFO_DEPTH-1:0]       wr_ptr_q;
   logic [LG_FIFO_DEPTH-1:0]       rd_ptr_q;
   logic [CNT_W-1:0]               count_q;
   logic [CNT_W-1:0]               count_d;
   logic [LG_TOKEN_DECIMATION-1:0] cons_q;
   logic                           token_q;
   logic                           overflow_q;
   logic                           push_c;
   logic                           pop_c;
   logic                           full_c;
   logic                           wr_en_c;

   assign beat_data_c = {io_data_ch1_i, io_data_ch0_i};
   assign push_c      = io_valid_in && (beat_q == BEAT_W'(BEATS - 1));
   assign pop_c       = core_yumi_i && (count_q != '0);
   assign full_c      = (count_q == CNT_W'(DEPTH));
   // A push at full is only accepted when the head is leaving in the same cycle.
   assign wr_en_c     = push_c && (!full_c || pop_c);

   // Current beat merged into the partial word; on the last beat this is the complete word.
   always_comb begin
      word_c = asm_q;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (beat_q == BEAT_W'(k)) word_c[k*BEAT_BITS +: BEAT_BITS] = beat_data_c;
      end
   end

   always_comb begin
      count_d = count_q;
      if (wr_en_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (!wr_en_c && pop_c) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_q     <= '0;
         asm_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         cons_q     <= '0;
         token_q    <= 1'b0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (io_valid_in) begin
            beat_q <= beat_q + BEAT_W'(1);
            asm_q  <= word_c;
         end
         if (wr_en_c) begin
            mem_q[wr_ptr_q] <= word_c;
            wr_ptr_q        <= wr_ptr_q + LG_FIFO_DEPTH'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + LG_FIFO_DEPTH'(1);
            cons_q   <= cons_q + LG_TOKEN_DECIMATION'(1);
            if (&cons_q) token_q <= ~token_q;
         end
         count_q <= count_d;
         if (push_c && full_c && !pop_c) overflow_q <= 1'b1;
      end
   end

   assign io_token_o   = token_q;
   assign overflow_o   = overflow_q;
   assign core_valid_o = (count_q != '0);
   assign core_data_o  = mem_q[rd_ptr_q];

`ifdef DOWNSTREAM_TOKEN_CNT_EN
   logic [6:0] token_cnt_q;
   logic [6:0] words_rcvd_q;

   // Credit accounting: token toggles and every completed word, dropped ones included.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         token_cnt_q  <= '0;
         words_rcvd_q <= '0;
      end else begin
         if (pop_c && (&cons_q)) token_cnt_q  <= token_cnt_q + 7'd1;
         if (push_c)             words_rcvd_q <= words_rcvd_q + 7'd1;
      end
   end

   assign token_cnt_o  = token_cnt_q;
   assign words_rcvd_o = words_rcvd_q;
`endif

endmodule

// File: tb/tb_downstream_token_out.sv
// Self-checking bench for downstream_token_out: directed scenarios plus random traffic against a queue model.
module tb_downstream_token_out;

   logic        clk;
   logic        rst_n;
   logic        io_valid_in;
   logic [7:0]  io_data_ch0_i;
   logic [7:0]  io_data_ch1_i;
   logic        io_token_o;
   logic        core_valid_o;
   logic [63:0] core_data_o;
   logic        core_yumi_i;
   logic        overflow_o;
`ifdef DOWNSTREAM_TOKEN_CNT_EN
   logic [6:0]  token_cnt_o;
   logic [6:0]  words_rcvd_o;
`endif

   downstream_token_out dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .io_valid_in   (io_valid_in),
      .io_data_ch0_i (io_data_ch0_i),
      .io_data_ch1_i (io_data_ch1_i),
      .io_token_o    (io_token_o),
      .core_valid_o  (core_valid_o),
      .core_data_o   (core_data_o),
      .core_yumi_i   (core_yumi_i),
      .overflow_o    (overflow_o)
`ifdef DOWNSTREAM_TOKEN_CNT_EN
      ,
      .token_cnt_o   (token_cnt_o),
      .words_rcvd_o  (words_rcvd_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: a word queue of credit depth, collected beats, and event totals.
   logic [63:0] exp_q[$];
   logic [15:0] beat_buf[$];
   int          pops;
   int          words;
   bit          exp_ovf;

   function automatic logic exp_token();
      return logic'((pops / 4) % 2);
   endfunction

   function automatic logic [63:0] exp_head();
      return (exp_q.size() > 0) ? exp_q[0] : 64'h0;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      beat_buf.delete();
      pops    = 0;
      words   = 0;
      exp_ovf = 0;
   endtask

   // One clock: drive inputs, advance the model with what the edge samples, settle past the edge.
   task automatic cycle(input bit v, input logic [7:0] c0, input logic [7:0] c1, input bit y);
      logic [63:0] w;
      io_valid_in   = v;
      io_data_ch0_i = c0;
      io_data_ch1_i = c1;
      core_yumi_i   = y;
      @(posedge clk);
      if (y && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         pops++;
      end
      if (v) begin
         beat_buf.push_back({c1, c0});
         if (beat_buf.size() == 4) begin
            w = {beat_buf[3], beat_buf[2], beat_buf[1], beat_buf[0]};
            beat_buf.delete();
            words++;
            if (exp_q.size() < 8) exp_q.push_back(w);
            else exp_ovf = 1;
         end
      end
      #1;
      io_valid_in = 1'b0;
      core_yumi_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      io_valid_in = 1'b0;
      core_yumi_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic send_word(input logic [63:0] w, input bit yumi_last);
      for (int b = 0; b < 4; b++)
         cycle(1'b1, w[16*b +: 8], w[16*b+8 +: 8], (b == 3) ? yumi_last : 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", core_valid_o); end
      checks++; if (core_data_o !== 64'h0) begin errors++; $display("FAIL reset_data got=%h want=0", core_data_o); end
      checks++; if (io_token_o !== 1'b0) begin errors++; $display("FAIL reset_token got=%b want=0", io_token_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow_o); end
   endtask

   task automatic test_single_word();
      logic [7:0] c0 [4] = '{8'h11, 8'h33, 8'h55, 8'h77};
      logic [7:0] c1 [4] = '{8'h22, 8'h44, 8'h66, 8'h88};
      do_reset();
      for (int b = 0; b < 4; b++) begin
         cycle(1'b1, c0[b], c1[b], 1'b0);
         checks++;
         if (core_valid_o !== (b == 3)) begin errors++; $display("FAIL single_valid beat=%0d got=%b want=%b", b, core_valid_o, (b == 3)); end
      end
      checks++; if (core_data_o !== 64'h8877665544332211) begin errors++; $display("FAIL single_data got=%h want=8877665544332211", core_data_o); end
      checks++; if (io_token_o !== 1'b0) begin errors++; $display("FAIL single_token got=%b want=0", io_token_o); end
   endtask

   task automatic test_gaps();
      logic [7:0] c0 [4] = '{8'h11, 8'h33, 8'h55, 8'h77};
      logic [7:0] c1 [4] = '{8'h22, 8'h44, 8'h66, 8'h88};
      do_reset();
      for (int b = 0; b < 4; b++) begin
         if (b > 0) begin
            for (int g = 0; g < 3; g++) begin
               cycle(1'b0, 8'hAA, 8'h55, 1'b0);
               checks++;
               if (core_valid_o !== 1'b0) begin errors++; $display("FAIL gap_valid beat=%0d got=%b want=0", b, core_valid_o); end
            end
         end
         cycle(1'b1, c0[b], c1[b], 1'b0);
      end
      checks++; if (core_valid_o !== 1'b1) begin errors++; $display("FAIL gap_word_valid got=%b want=1", core_valid_o); end
      checks++; if (core_data_o !== 64'h8877665544332211) begin errors++; $display("FAIL gap_data got=%h want=8877665544332211", core_data_o); end
      cycle(1'b0, 8'h0, 8'h0, 1'b1);
      checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL gap_after_pop got=%b want=0", core_valid_o); end
   endtask

   task automatic test_token_decimation();
      logic prev;
      int   toggles = 0;
      do_reset();
      prev = io_token_o;
      for (int w = 0; w < 8; w++) begin
         send_word({$urandom, $urandom}, 1'b0);
         checks++; if (core_data_o !== exp_head()) begin errors++; $display("FAIL tok_data w=%0d got=%h want=%h", w, core_data_o, exp_head()); end
         cycle(1'b0, 8'h0, 8'h0, 1'b1);
         checks++; if (io_token_o !== exp_token()) begin errors++; $display("FAIL tok_level pop=%0d got=%b want=%b", w + 1, io_token_o, exp_token()); end
         if (io_token_o !== prev) toggles++;
         prev = io_token_o;
      end
      checks++; if (toggles != 2) begin errors++; $display("FAIL tok_toggles got=%0d want=2", toggles); end
`ifdef DOWNSTREAM_TOKEN_CNT_EN
      checks++; if (token_cnt_o !== 7'd2) begin errors++; $display("FAIL tok_cnt got=%0d want=2", token_cnt_o); end
`endif
   endtask

   task automatic test_overflow();
      logic [63:0] sent[$];
      logic [63:0] w;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         w = {$urandom, $urandom};
         sent.push_back(w);
         send_word(w, 1'b0);
         checks++;
         if (overflow_o !== (i == 8)) begin errors++; $display("FAIL ovf_flag word=%0d got=%b want=%b", i + 1, overflow_o, (i == 8)); end
      end
      for (int i = 0; i < 8; i++) begin
         checks++; if (core_data_o !== sent[i]) begin errors++; $display("FAIL ovf_order idx=%0d got=%h want=%h", i, core_data_o, sent[i]); end
         cycle(1'b0, 8'h0, 8'h0, 1'b1);
      end
      checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b want=0", core_valid_o); end
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow_o); end
`ifdef DOWNSTREAM_TOKEN_CNT_EN
      checks++; if (words_rcvd_o !== 7'd9) begin errors++; $display("FAIL ovf_words got=%0d want=9", words_rcvd_o); end
`endif
   endtask

   task automatic test_full_push_pop();
      logic [63:0] sent[$];
      logic [63:0] w;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         w = {$urandom, $urandom};
         sent.push_back(w);
         send_word(w, i == 8);
      end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b want=0", overflow_o); end
      for (int i = 1; i < 9; i++) begin
         checks++; if (core_data_o !== sent[i]) begin errors++; $display("FAIL fpp_order idx=%0d got=%h want=%h", i, core_data_o, sent[i]); end
         cycle(1'b0, 8'h0, 8'h0, 1'b1);
      end
      checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL fpp_drained got=%b want=0", core_valid_o); end
   endtask

   task automatic test_reset_midword();
      do_reset();
      cycle(1'b1, 8'hDE, 8'hAD, 1'b0);
      cycle(1'b1, 8'hBE, 8'hEF, 1'b0);
      do_reset();
      send_word(64'h0807060504030201, 1'b0);
      checks++; if (core_valid_o !== 1'b1) begin errors++; $display("FAIL rmw_valid got=%b want=1", core_valid_o); end
      checks++; if (core_data_o !== 64'h0807060504030201) begin errors++; $display("FAIL rmw_data got=%h want=0807060504030201", core_data_o); end
      checks++; if (io_token_o !== 1'b0) begin errors++; $display("FAIL rmw_token got=%b want=0", io_token_o); end
      cycle(1'b0, 8'h0, 8'h0, 1'b1);
      checks++; if (core_valid_o !== 1'b0) begin errors++; $display("FAIL rmw_single got=%b want=0", core_valid_o); end
`ifdef DOWNSTREAM_TOKEN_CNT_EN
      checks++; if (token_cnt_o !== 7'd0) begin errors++; $display("FAIL rmw_tokcnt got=%0d want=0", token_cnt_o); end
      checks++; if (words_rcvd_o !== 7'd1) begin errors++; $display("FAIL rmw_words got=%0d want=1", words_rcvd_o); end
`endif
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
         checks++; if (core_valid_o !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, core_valid_o, (exp_q.size() > 0)); end
         if (exp_q.size() > 0) begin
            checks++; if (core_data_o !== exp_head()) begin errors++; $display("FAIL rnd_data n=%0d got=%h want=%h", n, core_data_o, exp_head()); end
         end
         checks++; if (io_token_o !== exp_token()) begin errors++; $display("FAIL rnd_token n=%0d got=%b want=%b", n, io_token_o, exp_token()); end
         checks++; if (overflow_o !== exp_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got=%b want=%b", n, overflow_o, exp_ovf); end
`ifdef DOWNSTREAM_TOKEN_CNT_EN
         checks++; if (token_cnt_o !== 7'((pops / 4) % 128)) begin errors++; $display("FAIL rnd_tokcnt n=%0d got=%0d want=%0d", n, token_cnt_o, (pops / 4) % 128); end
         checks++; if (words_rcvd_o !== 7'(words % 128)) begin errors++; $display("FAIL rnd_words n=%0d got=%0d want=%0d", n, words_rcvd_o, words % 128); end
`endif
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      io_valid_in   = 1'b0;
      io_data_ch0_i = 8'h0;
      io_data_ch1_i = 8'h0;
      core_yumi_i   = 1'b0;
      model_clear();
      test_reset();
      test_single_word();
      test_gaps();
      test_token_decimation();
      test_overflow();
      test_full_push_pop();
      test_reset_midword();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
